// File: rtl/sdm_decimator.sv
// Stereo sinc^3 CIC decimator: 1-bit PDM in, 24-bit saturated signed PCM out.
// Shared decimation counter and single-register valid/ready output stage.

module sdm_decimator_chan #(
    parameter int K = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        bit_in,
    input  logic        dec_stb,
    output logic [23:0] pcm
);
    localparam int W  = 3 * K + 2;
    localparam int SH = 23 - 3 * K;

    logic [W-1:0] i1, i2, i3;
    logic [W-1:0] d0, d1, d2;
    logic [W-1:0] x, i1_n, i2_n, i3_n;
    logic [W-1:0] c0, c1, c2, c3;
    logic signed [24:0] s;

    // Integrator and comb arithmetic wraps modulo 2^W by design.
    always_comb begin
        x    = bit_in ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
        i1_n = i1 + x;
        i2_n = i2 + i1_n;
        i3_n = i3 + i2_n;
        c0   = i3;
        c1   = c0 - d0;
        c2   = c1 - d1;
        c3   = c2 - d2;
        s    = $signed({{(25-W){c3[W-1]}}, c3} << SH);
        if (s > 25'sd8388607)
            pcm = 24'h7FFFFF;
        else if (s < -25'sd8388607)
            pcm = 24'h800001;
        else
            pcm = s[23:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i1 <= '0;
            i2 <= '0;
            i3 <= '0;
            d0 <= '0;
            d1 <= '0;
            d2 <= '0;
        end else begin
            if (in_valid) begin
                i1 <= i1_n;
                i2 <= i2_n;
                i3 <= i3_n;
            end
            if (dec_stb) begin
                d0 <= c0;
                d1 <= c1;
                d2 <= c2;
            end
        end
    end
endmodule

module sdm_decimator #(
    parameter int DECIM = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        sdm_in_l,
    input  logic        sdm_in_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_l,
    output logic [23:0] out_r,
    output logic        overrun
);
    localparam int K = $clog2(DECIM);

    logic [K-1:0] cnt;
    logic         dec_stb;
    logic [23:0]  pcm_l, pcm_r;

    sdm_decimator_chan #(.K(K)) u_chan_l (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .bit_in   (sdm_in_l),
        .dec_stb  (dec_stb),
        .pcm      (pcm_l)
    );

    sdm_decimator_chan #(.K(K)) u_chan_r (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .bit_in   (sdm_in_r),
        .dec_stb  (dec_stb),
        .pcm      (pcm_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            dec_stb <= 1'b0;
        end else begin
            dec_stb <= in_valid && (cnt == K'(DECIM - 1));
            if (in_valid)
                cnt <= cnt + 1'b1;
        end
    end

    // A load always wins; an unconsumed held sample gets replaced and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_l     <= '0;
            out_r     <= '0;
            overrun   <= 1'b0;
        end else if (dec_stb) begin
            out_l     <= pcm_l;
            out_r     <= pcm_r;
            out_valid <= 1'b1;
            if (out_valid && !out_ready)
                overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sdm_decimator.sv
// Bench for sdm_decimator: DECIM=64 and DECIM=8 instances, FIR reference model
// feeding a per-instance expected-sample queue, popped on each accepted output.

module tb_sdm_decimator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst, in_valid, sl, sr, out_ready;
    logic        ov0, ov1, ovr0, ovr1;
    logic [23:0] ol0, or0, ol1, or1;

    sdm_decimator #(.DECIM(64)) dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]),
        .sdm_in_l(sl[0]), .sdm_in_r(sr[0]),
        .out_valid(ov0), .out_ready(out_ready[0]),
        .out_l(ol0), .out_r(or0), .overrun(ovr0)
    );

    sdm_decimator #(.DECIM(8)) dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]),
        .sdm_in_l(sl[1]), .sdm_in_r(sr[1]),
        .out_valid(ov1), .out_ready(out_ready[1]),
        .out_l(ol1), .out_r(or1), .overrun(ovr1)
    );

    int errors = 0;
    int checks = 0;

    int D[2]   = '{64, 8};
    int SHF[2] = '{5, 14};
    int h[2][190];
    int hl[2][256];
    int hr[2][256];
    int n_acc[2], m_cnt[2];
    bit m_pend[2], m_valid[2], m_ovr[2];
    logic [23:0] pend_l[2], pend_r[2];
    logic [47:0] q0[$];
    logic [47:0] q1[$];

    int out_idx[2], last_t[2];
    int cyc_n = 0;
    bit const_en[2];
    int c_l[2], c_r[2];
    bit tol_en = 0, space_en = 0;

    task automatic chk(input string tag, input logic signed [47:0] obs, input logic signed [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int fir(input int i, input bit right);
        int acc = 0;
        int idx;
        for (int k = 0; k <= 3 * D[i] - 3; k++) begin
            idx = n_acc[i] - 1 - k;
            if (idx >= 0)
                acc += h[i][k] * (right ? hr[i][idx % 256] : hl[i][idx % 256]);
        end
        return acc;
    endfunction

    function automatic logic [23:0] scale_sat(input int i, input int y);
        longint s;
        s = longint'(y) * (longint'(1) << SHF[i]);
        if (s > 8388607) s = 8388607;
        else if (s < -8388607) s = -8388607;
        return s[23:0];
    endfunction

    task automatic model_step(input int i);
        if (rst[i]) begin
            m_cnt[i] = 0; n_acc[i] = 0; m_pend[i] = 0; m_valid[i] = 0; m_ovr[i] = 0;
            if (i == 0) q0.delete(); else q1.delete();
        end else begin
            if (m_pend[i]) begin
                if (m_valid[i] && !out_ready[i]) begin
                    m_ovr[i] = 1;
                    if (i == 0 && q0.size() > 0) void'(q0.pop_back());
                    if (i == 1 && q1.size() > 0) void'(q1.pop_back());
                end
                if (i == 0) q0.push_back({pend_l[i], pend_r[i]});
                else        q1.push_back({pend_l[i], pend_r[i]});
                m_valid[i] = 1;
            end else if (m_valid[i] && out_ready[i]) begin
                m_valid[i] = 0;
            end
            m_pend[i] = 0;
            if (in_valid[i]) begin
                hl[i][n_acc[i] % 256] = sl[i] ? 1 : -1;
                hr[i][n_acc[i] % 256] = sr[i] ? 1 : -1;
                n_acc[i]++;
                if (m_cnt[i] == D[i] - 1) begin
                    m_cnt[i]  = 0;
                    pend_l[i] = scale_sat(i, fir(i, 1'b0));
                    pend_r[i] = scale_sat(i, fir(i, 1'b1));
                    m_pend[i] = 1;
                end else begin
                    m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic accept_check(input int i);
        logic v;
        logic [23:0] al, ar;
        logic [47:0] e;
        int qs, dl, dr;
        v  = (i == 0) ? ov0 : ov1;
        al = (i == 0) ? ol0 : ol1;
        ar = (i == 0) ? or0 : or1;
        if (v === 1'b1 && out_ready[i] === 1'b1) begin
            out_idx[i]++;
            qs = (i == 0) ? q0.size() : q1.size();
            checks++;
            assert (qs > 0) else begin
                errors++;
                $error("FAIL sb_empty dut%0d observed=sample expected=none", i);
            end
            if (qs > 0) begin
                if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
                chk($sformatf("out_l dut%0d #%0d", i, out_idx[i]), $signed(al), $signed(e[47:24]));
                chk($sformatf("out_r dut%0d #%0d", i, out_idx[i]), $signed(ar), $signed(e[23:0]));
            end
            if (const_en[i] && out_idx[i] >= 3) begin
                chk($sformatf("const_l dut%0d", i), $signed(al), c_l[i]);
                chk($sformatf("const_r dut%0d", i), $signed(ar), c_r[i]);
            end
            if (i == 0 && tol_en && out_idx[i] >= 3) begin
                dl = int'($signed(al)) - 4194303;
                dr = int'($signed(ar)) + 4194303;
                chk("tol_l_within_512", (dl <= 512 && dl >= -512), 1);
                chk("tol_r_within_512", (dr <= 512 && dr >= -512), 1);
            end
            if (i == 0 && space_en && out_idx[i] >= 2)
                chk("spacing", cyc_n - last_t[i], 192);
            last_t[i] = cyc_n;
        end
        if (rst[i]) out_idx[i] = 0;
    endtask

    task automatic cyc();
        for (int i = 0; i < 2; i++) accept_check(i);
        for (int i = 0; i < 2; i++) model_step(i);
        @(posedge clk);
        #1;
        cyc_n++;
        chk("out_valid dut0", ov0, m_valid[0]);
        chk("overrun dut0", ovr0, m_ovr[0]);
        chk("out_valid dut1", ov1, m_valid[1]);
        chk("overrun dut1", ovr1, m_ovr[1]);
    endtask

    task automatic do_reset(input int i);
        rst[i] = 1'b1;
        in_valid[i] = 1'b0;
        cyc();
        rst[i] = 1'b0;
    endtask

    task automatic drive(input int i, input bit l, input bit r, input int gap);
        in_valid[i] = 1'b1;
        sl[i] = l;
        sr[i] = r;
        cyc();
        if (gap > 0) begin
            in_valid[i] = 1'b0;
            repeat (gap) cyc();
        end
    endtask

    initial begin
        int b2[255];
        bit l;
        longint acc_l, acc_r;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k <= 2 * D[i] - 2; k++)
                b2[k] = (k < D[i]) ? k + 1 : 2 * D[i] - 1 - k;
            for (int k = 0; k <= 3 * D[i] - 3; k++) begin
                h[i][k] = 0;
                for (int j = 0; j < D[i]; j++)
                    if (k - j >= 0 && k - j <= 2 * D[i] - 2) h[i][k] += b2[k - j];
            end
        end

        rst = 2'b11; in_valid = 2'b00; sl = 2'b00; sr = 2'b00; out_ready = 2'b11;
        cyc(); cyc();
        rst = 2'b00;
        chk("rst out_l dut0", $signed(ol0), 0);
        chk("rst out_r dut0", $signed(or0), 0);
        chk("rst out_l dut1", $signed(ol1), 0);
        chk("rst out_r dut1", $signed(or1), 0);
        chk("rst out_valid dut0", ov0, 0);
        chk("rst overrun dut1", ovr1, 0);

        // Constant ones / zeros / alternating, R carries the opposite bit.
        for (int p = 0; p < 3; p++) begin
            c_l[0] = (p == 0) ? 8388607 : (p == 1) ? -8388607 : 0;
            c_r[0] = (p == 0) ? -8388607 : (p == 1) ? 8388607 : 0;
            do_reset(0);
            const_en[0] = 1;
            for (int b = 0; b < 640; b++) begin
                l = (p == 0) ? 1'b1 : (p == 1) ? 1'b0 : (b % 2 == 0);
                drive(0, l, !l, 0);
                if (p == 0 && b == 63) chk("latency edge N", ov0, 0);
                if (p == 0 && b == 64) chk("latency edge N+1", ov0, 1);
            end
            in_valid[0] = 1'b0;
            repeat (3) cyc();
            chk("ten outputs", out_idx[0], 10);
            const_en[0] = 0;
        end

        // Backpressure across two periods: overwrite and sticky overrun.
        do_reset(0);
        out_ready[0] = 1'b0;
        for (int b = 0; b < 130; b++) drive(0, 1'b1, b[0], 0);
        in_valid[0] = 1'b0;
        cyc();
        chk("bp out_valid held", ov0, 1);
        chk("bp overrun set", ovr0, 1);
        out_ready[0] = 1'b1;
        for (int b = 0; b < 200; b++) drive(0, 1'b1, 1'b0, 0);
        in_valid[0] = 1'b0;
        repeat (3) cyc();
        chk("bp overrun sticky", ovr0, 1);
        do_reset(0);
        chk("bp overrun cleared by rst", ovr0, 0);

        // Accept exactly on the load cycle, random data.
        out_ready[0] = 1'b0;
        for (int b = 0; b <= 128; b++) begin
            if (b == 128) out_ready[0] = 1'b1;
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            if (b == 128) begin
                out_ready[0] = 1'b0;
                chk("sim out_valid stays", ov0, 1);
                chk("sim no overrun", ovr0, 0);
            end
        end
        in_valid[0] = 1'b0;
        cyc();
        out_ready[0] = 1'b1;
        repeat (3) cyc();

        // Sparse first-order PDM at +/-0.5 FS.
        do_reset(0);
        tol_en = 1; space_en = 1;
        acc_l = 0; acc_r = 0;
        for (int b = 0; b < 640; b++) begin
            bit bl, br;
            bl = (acc_l >= 0);
            br = (acc_r >= 0);
            acc_l = acc_l + 4194303 - (bl ? 8388607 : -8388607);
            acc_r = acc_r - 4194303 - (br ? 8388607 : -8388607);
            drive(0, bl, br, 2);
        end
        repeat (3) cyc();
        chk("sparse outputs", out_idx[0], 10);
        tol_en = 0; space_en = 0;

        // DECIM=8: reset mid-group with a held sample, then restart timing.
        do_reset(1);
        out_ready[1] = 1'b0;
        for (int b = 0; b < 13; b++) drive(1, 1'b1, 1'b0, 0);
        rst[1] = 1'b1;
        in_valid[1] = 1'b0;
        cyc();
        rst[1] = 1'b0;
        chk("d8 held discarded", ov1, 0);
        out_ready[1] = 1'b1;
        c_l[1] = 8388607; c_r[1] = -8388607;
        const_en[1] = 1;
        for (int b = 0; b < 80; b++) begin
            drive(1, 1'b1, 1'b0, 0);
            if (b == 7) chk("d8 latency edge N", ov1, 0);
            if (b == 8) chk("d8 latency edge N+1", ov1, 1);
        end
        in_valid[1] = 1'b0;
        repeat (5) cyc();
        chk("d8 outputs", out_idx[1], 10);
        const_en[1] = 0;

        checks++;
        assert (q0.size() == 0 && q1.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed=%0d/%0d expected=0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
